// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU over 32 shift
// cycles plus single-cycle MTHI/MTLO, owning the architectural HI/LO pair.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] opnd;
  logic [31:0] a_org;
  logic        neg_q;
  logic        neg_r;
  logic        is_div;
  logic        dz;

  logic        sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] prod;

  always_comb begin
    sgn    = ~op[0];
    abs_a  = (sgn & a[31]) ? (~a + 32'd1) : a;
    abs_b  = (sgn & b[31]) ? (~b + 32'd1) : b;
    sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? opnd : 32'd0)};
    rem_sh = {r_hi, r_lo[31]};
    diff   = rem_sh - {1'b0, opnd};
    prod   = neg_q ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      opnd   <= '0;
      a_org  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                cnt    <= '0;
                neg_q  <= sgn & (a[31] ^ b[31]);
                neg_r  <= sgn & a[31];
                is_div <= op[1];
                dz     <= (b == 32'd0);
                a_org  <= a;
                r_hi   <= '0;
                busy   <= 1'b1;
                // mul: {acc, multiplier}; div: {rem, dividend->quo}
                r_lo   <= op[1] ? abs_a : abs_b;
                opnd   <= op[1] ? abs_b : abs_a;
                state  <= op[1] ? S_DIV : S_MUL;
              end
              3'b100: hi <= a;
              3'b101: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_hi <= sum[32:1];
          r_lo <= {sum[0], r_lo[31:1]};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_DIV: begin
          // diff[32] set means the trial subtraction went negative
          r_hi <= diff[32] ? rem_sh[31:0] : diff[31:0];
          r_lo <= {r_lo[30:0], ~diff[32]};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div && dz) begin
            hi <= a_org;
            lo <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            hi <= neg_r ? (~r_hi + 32'd1) : r_hi;
            lo <= neg_q ? (~r_lo + 32'd1) : r_lo;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at issue,
// popped and compared by a monitor on every done pulse.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk;
  int n_fail;
  int n_push;
  int n_done;
  logic [63:0] exp_q[$];

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      logic [63:0] e;
      n_done++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got done=1 expected no pulse");
      end else begin
        e = exp_q.pop_front();
        chk("res_hi", hi, e[63:32]);
        chk("res_lo", lo, e[31:0]);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] eh,
                     input logic [31:0] el);
    int cyc;
    exp_q.push_back({eh, el});
    n_push++;
    issue(o, x, y);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("busy_len", cyc, 33);
    chk("done_after", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [31:0] h0;
    n_chk = 0; n_fail = 0; n_push = 0; n_done = 0;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    run(3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run(3'b011, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run(3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    run(3'b000, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000);
    run(3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI/MTLO and an ignored opcode
    issue(3'b101, 32'h1111_2222, 32'd0);
    chk("mtlo_lo", lo, 32'h1111_2222);
    chk("mtlo_hi", hi, 32'hFFFF_FFF9);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    issue(3'b110, 32'h5555_5555, 32'd0);
    chk("op6_hi", hi, 32'hFFFF_FFF9);
    chk("op6_lo", lo, 32'h1111_2222);
    chk("op6_busy", {31'd0, busy}, 32'd0);

    // start while busy is dropped; MTHI in the done cycle is taken
    exp_q.push_back({32'd0, 32'd30});
    n_push++;
    issue(3'b000, 32'd5, 32'd6);
    repeat (4) @(posedge clk);
    #1 issue(3'b100, 32'hDEAD_BEEF, 32'd0);
    chk("busy_hold_hi", hi, 32'hFFFF_FFF9);
    chk("busy_hold_lo", lo, 32'h1111_2222);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("busy_len_e5", cyc, 28);
    issue(3'b100, 32'hCAFE_F00D, 32'd0);
    chk("mthi_hi", hi, 32'hCAFE_F00D);
    chk("mthi_lo", lo, 32'd30);

    // reset at E10 of a DIVU aborts it
    h0 = 32'd0;
    issue(3'b011, 32'hFFFF_0000, 32'd3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_hi", hi, h0);
    chk("abort_lo", lo, h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("done_count", n_done, n_push);
    chk("queue_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
